fp_sqrt_nr: RTL and testbench

//  IEEE-754 single-precision square root by Newton-Raphson, x' = (a/x + x)/2.

---
 rtl/fp_sqrt_nr_if.sv | 13 +
 rtl/fp_sqrt_nr.sv | 204 ++++++++++++++++++++
 tb/tb_fp_sqrt_nr.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fp_sqrt_nr_if.sv
// Request/result bundle between the sqrt unit and its requester.
interface fp_sqrt_nr_if;
   logic        start;
   logic [31:0] argument;
   logic [31:0] result;
   logic        busy;
   logic        done;
   logic        invalid;
   logic [3:0]  iter_count;

   modport master (output start, argument, input result, busy, done, invalid, iter_count);
   modport slave  (input start, argument, output result, busy, done, invalid, iter_count);
endinterface

// File: rtl/fp_sqrt_nr.sv
// Newton-Raphson single-precision square root, x' = (a/x + x)/2, with the
// iterative mantissa divider and positive-operand adder it drives.

module fp_sqrt_nr_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  logic [30:0] i_a,
   input  logic [30:0] i_b,
   output logic [30:0] o_q,
   output logic        o_ready
);
   logic [4:0]  r_cnt;
   logic [24:0] r_rem;
   logic [24:0] r_q;
   logic        r_ready;
   logic [23:0] w_mb;
   logic [7:0]  w_e;

   assign w_mb = {1'b1, i_b[22:0]};
   // one restoring step per cycle; operands must stay stable while enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_ready <= 1'b0;
      end else if (!i_en) begin
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else if (r_cnt == 5'd0) begin
         r_rem <= {1'b0, 1'b1, i_a[22:0]};
         r_q   <= '0;
         r_cnt <= 5'd1;
      end else if (!r_ready) begin
         if (r_rem >= {1'b0, w_mb}) begin
            r_q   <= {r_q[23:0], 1'b1};
            r_rem <= (r_rem - {1'b0, w_mb}) << 1;
         end else begin
            r_q   <= {r_q[23:0], 1'b0};
            r_rem <= r_rem << 1;
         end
         r_cnt <= r_cnt + 5'd1;
         if (r_cnt == 5'd25) r_ready <= 1'b1;
      end
   end

   assign w_e     = i_a[30:23] - i_b[30:23] + (r_q[24] ? 8'd127 : 8'd126);
   assign o_q     = {w_e, r_q[24] ? r_q[23:1] : r_q[22:0]};
   assign o_ready = r_ready;
endmodule

module fp_sqrt_nr_add (
   input  logic        i_en,
   input  logic [30:0] i_a,
   input  logic [30:0] i_b,
   output logic [31:0] o_sum
);
   logic        w_swap;
   logic [30:0] w_big, w_sml;
   logic [7:0]  w_d;
   logic [23:0] w_ms;
   logic [24:0] w_s;

   assign w_swap = i_b[30:23] > i_a[30:23];
   assign w_big  = w_swap ? i_b : i_a;
   assign w_sml  = w_swap ? i_a : i_b;
   assign w_d    = w_big[30:23] - w_sml[30:23];
   assign w_ms   = {1'b1, w_sml[22:0]} >> w_d;
   assign w_s    = {2'b01, w_big[22:0]} + {1'b0, w_ms};
   assign o_sum  = !i_en  ? 32'h0 :
                   w_s[24] ? {1'b0, w_big[30:23] + 8'd1, w_s[23:1]} :
                             {1'b0, w_big[30:23], w_s[22:0]};
endmodule

module fp_sqrt_nr #(
   parameter int          ITERS      = 5,
   parameter int          SEED_MODE  = 1,
   parameter logic [31:0] SEED       = 32'h3F000000,
   parameter int          ADD_LAT    = 15,
   parameter int          EARLY_EXIT = 1
) (
   input  logic         clk,
   input  logic         reset,
   fp_sqrt_nr_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, SPECIAL, DIV_WAIT, ADD_RUN, UPDATE} state_t;

   state_t      r_state, w_next;
   logic [31:0] r_a, r_x, r_sum, r_result;
   logic [30:0] r_q;
   logic        r_busy, r_done, r_invalid;
   logic [3:0]  r_iter, r_add_cnt;
   logic [2:0]  r_rdy_sync;

   logic        w_div_en, w_add_en, w_div_rdy, w_div_done, w_add_last;
   logic        w_accept, w_arg_special, w_fin, w_spec_inv;
   logic [30:0] w_div_q;
   logic [31:0] w_add_sum, w_xn, w_seed, w_spec_res;
   logic [7:0]  w_seed_e;
   logic [3:0]  w_iter_nx;

   fp_sqrt_nr_div u_div (.clk(clk), .rst(reset), .i_en(w_div_en), .i_a(r_a[30:0]),
                         .i_b(r_x[30:0]), .o_q(w_div_q), .o_ready(w_div_rdy));
   fp_sqrt_nr_add u_add (.i_en(w_add_en), .i_a(r_q), .i_b(r_x[30:0]), .o_sum(w_add_sum));

   // zero, denormal, inf, NaN and any negative all bypass the iteration
   assign w_arg_special = (bus.argument[30:23] == 8'h00) || (bus.argument[30:23] == 8'hFF)
                          || bus.argument[31];
   assign w_accept   = (r_state == IDLE) && bus.start && !r_done;
   // ((e-127)>>>1)+127 rewritten as (e+127)>>1, identical for every biased e
   assign w_seed_e   = 8'(({1'b0, bus.argument[30:23]} + 9'd127) >> 1);
   assign w_seed     = (SEED_MODE != 0) ? {1'b0, w_seed_e, 23'b0} : SEED;
   assign w_div_done = r_rdy_sync[1] && !r_rdy_sync[2];
   assign w_add_last = (r_add_cnt == 4'(ADD_LAT - 1));
   assign w_xn       = (r_sum[30:23] == 8'h00) ? r_sum
                                               : {r_sum[31], r_sum[30:23] - 8'd1, r_sum[22:0]};
   assign w_iter_nx  = r_iter + 4'd1;
   assign w_fin      = (w_iter_nx == 4'(ITERS)) || ((EARLY_EXIT != 0) && (w_xn == r_x));

   always_comb begin
      w_spec_inv = 1'b0;
      if (r_a[30:23] == 8'h00)      w_spec_res = {r_a[31], 31'b0};
      else if (r_a == 32'h7F800000) w_spec_res = 32'h7F800000;
      else begin
         w_spec_res = 32'h7FC00000;
         w_spec_inv = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_accept) w_next = w_arg_special ? SPECIAL : DIV_WAIT;
         SPECIAL:  w_next = IDLE;
         DIV_WAIT: if (w_div_done) w_next = ADD_RUN;
         ADD_RUN:  if (w_add_last) w_next = UPDATE;
         UPDATE:   w_next = w_fin ? IDLE : DIV_WAIT;
         default:  w_next = IDLE;
      endcase
   end

   always_comb begin
      w_div_en = (r_state == DIV_WAIT);
      w_add_en = (r_state == ADD_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a <= '0;  r_x <= SEED;  r_q <= '0;  r_sum <= '0;  r_result <= SEED;
         r_busy <= 1'b0;  r_done <= 1'b0;  r_invalid <= 1'b0;
         r_iter <= '0;  r_add_cnt <= '0;  r_rdy_sync <= '0;
      end else begin
         r_done     <= 1'b0;
         r_rdy_sync <= {r_rdy_sync[1:0], w_div_rdy};
         case (r_state)
            IDLE: if (w_accept) begin
               r_a       <= bus.argument;
               r_invalid <= 1'b0;
               r_iter    <= '0;
               r_busy    <= 1'b1;
               if (!w_arg_special) r_x <= w_seed;
            end
            SPECIAL: begin
               r_result  <= w_spec_res;
               r_invalid <= w_spec_inv;
               r_iter    <= '0;
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
            end
            DIV_WAIT: begin
               r_add_cnt <= '0;
               if (w_div_done) r_q <= w_div_q;
            end
            ADD_RUN: begin
               r_add_cnt <= r_add_cnt + 4'd1;
               if (w_add_last) r_sum <= w_add_sum;
            end
            UPDATE: begin
               r_iter <= w_iter_nx;
               if (w_fin) begin
                  r_result <= w_xn;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
               end else begin
                  r_x <= w_xn;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result     = r_result;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.invalid    = r_invalid;
   assign bus.iter_count = r_iter;
endmodule

// File: tb/tb_fp_sqrt_nr.sv
// Directed bench for fp_sqrt_nr: expectations queued at issue, popped on done.
module tb_fp_sqrt_nr;
   typedef struct {
      logic [31:0] res;
      int          tol;
      logic        inv;
      int          max_iter;
      int          lat;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   exp_t sb[$];

   fp_sqrt_nr_if bus();

   fp_sqrt_nr #(.ITERS(5), .SEED_MODE(1), .SEED(32'h3F000000), .ADD_LAT(15), .EARLY_EXIT(1))
      dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                          input int tol);
      logic [31:0] diff;
      diff = (obs >= exp) ? obs - exp : exp - obs;
      total++;
      assert (!$isunknown(obs) && diff <= 32'(tol)) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp, tol);
      end
   endtask

   task automatic chk_le(input string tag, input int obs, input int lim);
      total++;
      assert (obs <= lim) else begin
         bad++;
         $error("FAIL %s observed=%0d expected<=%0d", tag, obs, lim);
      end
   endtask

   // mode 1: re-pulse start with a new operand while busy
   // mode 2: raise start in the same cycle as done
   task automatic run_op(input logic [31:0] arg, input logic [31:0] res, input int tol,
                         input logic inv, input int max_iter, input int lat,
                         input string tag, input int mode);
      exp_t e;
      int   cyc;
      int   d0;
      e.res = res; e.tol = tol; e.inv = inv; e.max_iter = max_iter; e.lat = lat; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      bus.argument = arg;
      bus.start    = 1'b1;
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      if (mode == 1) begin
         chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
         bus.argument = 32'h41800000;
         bus.start    = 1'b1;
         @(negedge clk);
         cyc++;
         bus.start    = 1'b0;
      end
      while (bus.done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      e = sb.pop_front();
      chk({e.tag, "_done_seen"}, {31'b0, bus.done}, 32'd1);
      chk_tol({e.tag, "_result"}, bus.result, e.res, e.tol);
      chk({e.tag, "_invalid"}, {31'b0, bus.invalid}, {31'b0, e.inv});
      chk({e.tag, "_busy_low"}, {31'b0, bus.busy}, 32'd0);
      chk_le({e.tag, "_iters"}, int'(bus.iter_count), e.max_iter);
      if (e.lat != 0) chk({e.tag, "_latency"}, cyc, e.lat);
      if (mode == 2) begin
         bus.argument = 32'h40800000;
         bus.start    = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk({e.tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
      chk({e.tag, "_done_count"}, done_cnt - d0, 32'd1);
      if (mode == 2) chk({e.tag, "_start_at_done_ignored"}, {31'b0, bus.busy}, 32'd0);
   endtask

   initial begin
      int d0;
      bus.start    = 1'b0;
      bus.argument = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_result", bus.result, 32'h3F000000);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_done", {31'b0, bus.done}, 32'd0);
      chk("rst_invalid", {31'b0, bus.invalid}, 32'd0);
      chk("rst_iter", {28'b0, bus.iter_count}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(32'h40800000, 32'h40000000, 0, 1'b0, 1, 0, "T1_sqrt4", 0);
      run_op(32'h40000000, 32'h3FB504F3, 1, 1'b0, 5, 0, "T2_sqrt2", 0);
      run_op(32'h3F800000, 32'h3F800000, 0, 1'b0, 4, 0, "T3_sqrt1", 0);
      run_op(32'h80000000, 32'h80000000, 0, 1'b0, 0, 2, "T4_negzero", 0);
      run_op(32'h7F800000, 32'h7F800000, 0, 1'b0, 0, 2, "T4_posinf", 0);
      run_op(32'hBF800000, 32'h7FC00000, 0, 1'b1, 0, 2, "T4_neg1", 0);
      run_op(32'h7FC00001, 32'h7FC00000, 0, 1'b1, 0, 2, "nan_in", 0);
      run_op(32'h00400000, 32'h00000000, 0, 1'b0, 0, 2, "denormal", 0);
      run_op(32'h00000000, 32'h00000000, 0, 1'b0, 0, 2, "poszero", 0);
      run_op(32'h3E800000, 32'h3F000000, 0, 1'b0, 1, 0, "sqrt_quarter", 0);
      run_op(32'h41100000, 32'h40400000, 1, 1'b0, 5, 0, "sqrt9", 0);
      run_op(32'h40800000, 32'h40000000, 0, 1'b0, 1, 0, "T5_busy_start", 1);
      run_op(32'h41800000, 32'h40800000, 0, 1'b0, 1, 0, "sqrt16_start_at_done", 2);

      // T6: abort in the middle of the first divide
      @(negedge clk);
      bus.argument = 32'h40000000;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      d0 = done_cnt;
      reset = 1'b1;
      #1;
      chk("T6_busy_at_reset", {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      chk("T6_no_done", done_cnt - d0, 32'd0);
      chk("T6_result_reset", bus.result, 32'h3F000000);
      run_op(32'h40800000, 32'h40000000, 0, 1'b0, 1, 0, "T6_after_reset", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
